// File: rtl/clk_divider_bank_if.sv
// Control and status bundle for clk_divider_bank.
// The master side drives run enables and divisor loads. The slave side is the
// divider bank, which returns the divided levels, tick strobes and pending flags.
interface clk_divider_bank_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 17
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] EN;
  logic              LOAD;
  logic [CH_W-1:0]   LOAD_CH;
  logic [CNT_W-1:0]  LOAD_DIV;
  logic [NUM_CH-1:0] CLK_OUT;
  logic [NUM_CH-1:0] TICK;
  logic [NUM_CH-1:0] PENDING;

  modport master (
    output EN, LOAD, LOAD_CH, LOAD_DIV,
    input  CLK_OUT, TICK, PENDING
  );

  modport slave (
    input  EN, LOAD, LOAD_CH, LOAD_DIV,
    output CLK_OUT, TICK, PENDING
  );
endinterface

// File: rtl/clk_divider_bank.sv
// Multi-channel programmable slow-clock / tick generator.
// Each channel counts 0..div_active. At the top of the count it toggles its
// 50%-duty level and pulses a one-cycle tick. A new divisor is parked in a
// shadow register and only takes effect at a period boundary, so the level
// output never sees a runt half-period. "Boundary" means either a wrap or a
// cycle with the channel disabled. In both cases the counter restarts at 0,
// which keeps cnt <= div_active at all times.
module clk_divider_bank #(
  parameter int          NUM_CH    = 3,
  parameter int          CNT_W     = 17,
  parameter int unsigned DIV_RESET = 2**CNT_W - 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  clk_divider_bank_if.slave bus
);
  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] pend_v;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(ch);

    logic [CNT_W-1:0] cnt,        cnt_d;
    logic [CNT_W-1:0] div_active, div_active_d;
    logic [CNT_W-1:0] div_shadow, div_shadow_d;
    logic             clk_q,      clk_d;
    logic             tick_q,     tick_d;
    logic             pend_q,     pend_d;
    logic             load_hit;
    logic             wrap;
    logic             boundary;

    // Out-of-range channel indices never match, so they are silently dropped.
    assign load_hit = bus.LOAD && (bus.LOAD_CH == CH_IDX);
    // Equality compare keeps the full-range divisor from overflowing the counter.
    assign wrap     = (cnt == div_active);
    assign boundary = !bus.EN[ch] || wrap;

    // Next-state: counting, toggling and divisor hand-over for one channel.
    always_comb begin
      cnt_d        = cnt;
      div_active_d = div_active;
      div_shadow_d = div_shadow;
      clk_d        = clk_q;
      tick_d       = 1'b0;
      pend_d       = pend_q;

      if (!bus.EN[ch]) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (wrap) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end

      if (boundary) begin
        // A load arriving on the boundary cycle itself goes straight to the
        // active divisor; otherwise any parked value is promoted.
        if (load_hit) begin
          div_active_d = bus.LOAD_DIV;
          div_shadow_d = bus.LOAD_DIV;
          pend_d       = 1'b0;
        end else if (pend_q) begin
          div_active_d = div_shadow;
          pend_d       = 1'b0;
        end
      end else if (load_hit) begin
        // Mid-period load: park it. A later load overwrites the earlier one.
        div_shadow_d = bus.LOAD_DIV;
        pend_d       = 1'b1;
      end
    end

    // State register; reset discards any parked divisor.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt        <= '0;
        div_active <= DIV_INIT;
        div_shadow <= DIV_INIT;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        cnt        <= cnt_d;
        div_active <= div_active_d;
        div_shadow <= div_shadow_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        pend_q     <= pend_d;
      end
    end

    assign clk_out_v[ch] = clk_q;
    assign tick_v[ch]    = tick_q;
    assign pend_v[ch]    = pend_q;
  end

  assign bus.CLK_OUT = clk_out_v;
  assign bus.TICK    = tick_v;
  assign bus.PENDING = pend_v;
endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank with NUM_CH=3, CNT_W=4, DIV_RESET=3.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so they show the result of the edge just taken.
module tb_clk_divider_bank;
  logic CLOCK;
  logic RESET_N;
  int   n_cmp = 0;
  int   n_err = 0;

  clk_divider_bank_if #(.NUM_CH(3), .CNT_W(4)) bus ();

  clk_divider_bank #(.NUM_CH(3), .CNT_W(4), .DIV_RESET(3)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  // 10-unit clock period.
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(posedge CLOCK);
    #1;
  endtask

  // One edge, then check all three output vectors.
  task automatic cyc(input logic [2:0] ec, input logic [2:0] et, input logic [2:0] ep,
                     input string tag);
    tk();
    chk({tag, "_clk"},  bus.CLK_OUT, ec);
    chk({tag, "_tick"}, bus.TICK,    et);
    chk({tag, "_pend"}, bus.PENDING, ep);
  endtask

  task automatic load(input logic [1:0] ch, input logic [3:0] d);
    bus.LOAD     = 1'b1;
    bus.LOAD_CH  = ch;
    bus.LOAD_DIV = d;
  endtask

  initial begin
    logic [2:0] ec;
    logic [2:0] et;
    bus.EN       = 3'b000;
    bus.LOAD     = 1'b0;
    bus.LOAD_CH  = 2'd0;
    bus.LOAD_DIV = 4'd0;
    RESET_N      = 1'b1;
    #2 RESET_N   = 1'b0;

    // Reset state.
    tk();
    tk();
    chk("rst_clk",  bus.CLK_OUT, 3'b000);
    chk("rst_tick", bus.TICK,    3'b000);
    chk("rst_pend", bus.PENDING, 3'b000);

    // 1: ch0 alone with D=3. It toggles on every 4th edge.
    RESET_N = 1'b1;
    bus.EN  = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      ec = {2'b00, ((k / 4) % 2) == 1};
      et = {2'b00, (k % 4) == 0};
      cyc(ec, et, 3'b000, "t1_run");
    end

    // 2: Load D=1 into ch0 at cnt=1. The current half-period stays 4 cycles.
    cyc(3'b001, 3'b000, 3'b000, "t2_cnt1");
    load(2'd0, 4'd1);
    cyc(3'b001, 3'b000, 3'b001, "t2_parked");
    bus.LOAD = 1'b0;
    cyc(3'b001, 3'b000, 3'b001, "t2_wait");
    cyc(3'b000, 3'b001, 3'b000, "t2_wrap");
    cyc(3'b000, 3'b000, 3'b000, "t2_half2a");
    cyc(3'b001, 3'b001, 3'b000, "t2_half2b");
    cyc(3'b001, 3'b000, 3'b000, "t2_half2c");
    cyc(3'b000, 3'b001, 3'b000, "t2_half2d");

    // 3: Load D=0 into disabled ch1. It is applied directly, then ch1 is enabled.
    load(2'd1, 4'd0);
    cyc(3'b000, 3'b000, 3'b000, "t3_load_dis");
    bus.LOAD = 1'b0;
    bus.EN   = 3'b011;
    cyc(3'b011, 3'b011, 3'b000, "t3_run_a");
    cyc(3'b001, 3'b010, 3'b000, "t3_run_b");
    cyc(3'b010, 3'b011, 3'b000, "t3_run_c");
    cyc(3'b000, 3'b010, 3'b000, "t3_run_d");

    // 4: Load D=5 into ch0 on its wrap cycle, then load to out-of-range channel 3.
    load(2'd0, 4'd5);
    cyc(3'b011, 3'b011, 3'b000, "t4_wrap_load");
    load(2'd3, 4'd0);
    cyc(3'b001, 3'b010, 3'b000, "t4_bad_ch");
    bus.LOAD = 1'b0;
    cyc(3'b011, 3'b010, 3'b000, "t4_h6_b");
    cyc(3'b001, 3'b010, 3'b000, "t4_h6_c");
    cyc(3'b011, 3'b010, 3'b000, "t4_h6_d");
    cyc(3'b001, 3'b010, 3'b000, "t4_h6_e");
    cyc(3'b010, 3'b011, 3'b000, "t4_h6_wrap");

    // 5: ch2 alone with full-range D=15, a mid-period disable, then re-enable.
    bus.EN = 3'b000;
    load(2'd2, 4'd15);
    cyc(3'b000, 3'b000, 3'b000, "t5_load");
    bus.LOAD = 1'b0;
    bus.EN   = 3'b100;
    for (int i = 0; i < 15; i++) cyc(3'b000, 3'b000, 3'b000, "t5_cnt");
    cyc(3'b100, 3'b100, 3'b000, "t5_wrap");
    for (int i = 0; i < 6; i++) cyc(3'b100, 3'b000, 3'b000, "t5_high");
    bus.EN = 3'b000;
    cyc(3'b000, 3'b000, 3'b000, "t5_drop");
    bus.EN = 3'b100;
    for (int i = 0; i < 15; i++) cyc(3'b000, 3'b000, 3'b000, "t5_recnt");
    cyc(3'b100, 3'b100, 3'b000, "t5_rewrap");

    // 6: Reset while ch0 has a parked divisor. After release every channel runs D=3.
    bus.EN = 3'b101;
    cyc(3'b100, 3'b000, 3'b000, "t6_run");
    load(2'd0, 4'd0);
    cyc(3'b100, 3'b000, 3'b001, "t6_parked");
    bus.LOAD = 1'b0;
    #3 RESET_N = 1'b0;
    #1;
    chk("t6_async_clk",  bus.CLK_OUT, 3'b000);
    chk("t6_async_tick", bus.TICK,    3'b000);
    chk("t6_async_pend", bus.PENDING, 3'b000);
    tk();
    RESET_N = 1'b1;
    bus.EN  = 3'b111;
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000, 3'b000, "t6_cnt_a");
    cyc(3'b111, 3'b111, 3'b000, "t6_wrap_a");
    for (int i = 0; i < 3; i++) cyc(3'b111, 3'b000, 3'b000, "t6_cnt_b");
    cyc(3'b000, 3'b111, 3'b000, "t6_wrap_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
